user_mac_sequencer: RTL and testbench

Fetches packed operand pairs from the user-domain ROM (0x2000_0000–0x2000_0FFF) over an OBI manager port. Streams each pair into the MAC accelerator datapath through a valid/ready handshake and returns the final accumulator value to software-visible config logic. It sits in the user domain between the user demux (as an additional OBI manager) and the MAC datapath, and runs one job at a time.

---
 rtl/user_mac_sequencer_if.sv | 29 ++
 rtl/user_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_user_mac_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_mac_sequencer_if.sv
// OBI read-manager and MAC operand-stream signals between the sequencer and its user-domain neighbours.
// master = sequencer side, slave = ROM interconnect plus MAC datapath side.
interface user_mac_sequencer_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                 obi_req;
  logic [AddrWidth-1:0] obi_addr;
  logic                 obi_gnt;
  logic                 obi_rvalid;
  logic [DataWidth-1:0] obi_rdata;
  logic                 obi_err;
  logic                 mac_clear;
  logic                 mac_valid;
  logic                 mac_ready;
  logic [15:0]          mac_a;
  logic [15:0]          mac_b;
  logic [31:0]          mac_acc;

  modport master (
    output obi_req, obi_addr, mac_clear, mac_valid, mac_a, mac_b,
    input  obi_gnt, obi_rvalid, obi_rdata, obi_err, mac_ready, mac_acc
  );

  modport slave (
    input  obi_req, obi_addr, mac_clear, mac_valid, mac_a, mac_b,
    output obi_gnt, obi_rvalid, obi_rdata, obi_err, mac_ready, mac_acc
  );
endinterface

// File: rtl/user_mac_sequencer.sv
// User-domain MAC operand sequencer: fetches packed (a,b) words from ROM over OBI,
// streams them into the MAC datapath and captures the final accumulator.
module user_mac_sequencer #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          result_o,
  user_mac_sequencer_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start_i
  // CLEAR | one-cycle accumulator clear
  // REQ   | OBI request held until grant
  // WAIT  | waiting for the OBI response
  // ISSUE | operand pair offered to the MAC until ready
  // DRAIN | lets the last accepted pair reach the accumulator
  // DONE  | done pulse, result valid
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q;
  logic [AddrWidth-1:0] base_q;
  logic [LenWidth-1:0]  len_q;
  logic [LenWidth-1:0]  idx_q;
  logic [LenWidth-1:0]  idx_inc;

  assign idx_inc = idx_q + LenWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      result_o      <= '0;
      bus.obi_req   <= 1'b0;
      bus.obi_addr  <= '0;
      bus.mac_clear <= 1'b0;
      bus.mac_valid <= 1'b0;
      bus.mac_a     <= '0;
      bus.mac_b     <= '0;
    end else begin
      done_o        <= 1'b0;
      bus.mac_clear <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q        <= base_addr_i & ~AddrWidth'(3);
            len_q         <= len_i;
            idx_q         <= '0;
            err_o         <= 1'b0;
            busy_o        <= 1'b1;
            bus.mac_clear <= 1'b1;
            state_q       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (len_q == '0) begin
            // The accumulator is being cleared this cycle, so an empty job reports zero.
            result_o <= '0;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            bus.obi_req  <= 1'b1;
            bus.obi_addr <= base_q;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.obi_gnt) begin
            bus.obi_req <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.obi_rvalid) begin
            if (bus.obi_err) begin
              err_o    <= 1'b1;
              result_o <= bus.mac_acc;
              done_o   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              bus.mac_a     <= bus.obi_rdata[15:0];
              bus.mac_b     <= bus.obi_rdata[DataWidth/2 +: 16];
              bus.mac_valid <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.mac_ready) begin
            bus.mac_valid <= 1'b0;
            idx_q         <= idx_inc;
            if (idx_inc == len_q) begin
              state_q <= S_DRAIN;
            end else begin
              // Address arithmetic wraps modulo 2^AddrWidth.
              bus.obi_req  <= 1'b1;
              bus.obi_addr <= base_q + AddrWidth'({idx_inc, 2'b00});
              state_q      <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          result_o <= bus.mac_acc;
          done_o   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_o        <= 1'b0;
          bus.obi_req   <= 1'b0;
          bus.mac_valid <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_user_mac_sequencer.sv
// Bench for user_mac_sequencer: ROM/OBI and MAC responders with configurable stalls,
// checked per job against a pair-level reference model.
module tb_user_mac_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [9:0]  len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;

  int tests_run = 0;
  int tests_failed = 0;

  user_mac_sequencer_if bus ();

  user_mac_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .result_o(result_o),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  // Per-job environment configuration, indexed by pair number
  int gnt_stall [64];
  int rv_lat    [64];
  int rdy_stall [64];
  int err_at;
  logic [31:0] rom [logic [31:0]];

  // Observations
  logic [31:0] addr_log [$];
  logic [31:0] pair_log [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_pair [$];
  int clear_cnt, req_seen, stable_err;
  int req_n, iss_n;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (rom.exists(a)) return rom[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int q_diff(input logic [31:0] a [$], input logic [31:0] b [$]);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // OBI ROM responder: grant after a configured stall, respond after a configured latency
  int stall_left, lat_left;
  bit pend, stalling;
  logic [31:0] pend_addr, held_addr;
  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.obi_gnt = 1'b0; bus.obi_rvalid = 1'b0; bus.obi_err = 1'b0; bus.obi_rdata = '0;
      pend = 1'b0; stalling = 1'b0;
    end else begin
      bus.obi_gnt = 1'b0; bus.obi_rvalid = 1'b0; bus.obi_err = 1'b0;
      if (pend) begin
        if (lat_left > 0) lat_left--;
        else begin
          bus.obi_rvalid = 1'b1;
          bus.obi_rdata  = rom_word(pend_addr);
          bus.obi_err    = ((req_n - 1) == err_at);
          pend = 1'b0;
        end
      end else if (bus.obi_req) begin
        if (!stalling) begin
          stalling = 1'b1; stall_left = gnt_stall[req_n % 64]; held_addr = bus.obi_addr;
        end else if (bus.obi_addr !== held_addr) stable_err++;
        if (stall_left > 0) stall_left--;
        else begin
          bus.obi_gnt = 1'b1; pend = 1'b1; stalling = 1'b0;
          lat_left = rv_lat[req_n % 64]; pend_addr = bus.obi_addr;
          addr_log.push_back(bus.obi_addr);
          req_n++;
        end
      end
    end
  end

  // MAC responder: ready after a configured stall; accumulator model on the clock edge
  int rdy_left;
  bit rdy_active;
  logic [31:0] held_ab;
  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.mac_ready = 1'b0; rdy_active = 1'b0;
    end else if (bus.mac_valid) begin
      if (!rdy_active) begin
        rdy_active = 1'b1; rdy_left = rdy_stall[iss_n % 64]; held_ab = {bus.mac_b, bus.mac_a};
      end else if ({bus.mac_b, bus.mac_a} !== held_ab) stable_err++;
      if (rdy_left > 0) begin rdy_left--; bus.mac_ready = 1'b0; end
      else begin bus.mac_ready = 1'b1; rdy_active = 1'b0; iss_n++; end
    end else bus.mac_ready = 1'($urandom_range(0, 1));
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bus.mac_acc <= '0;
    else if (bus.mac_clear) bus.mac_acc <= '0;
    else if (bus.mac_valid && bus.mac_ready) begin
      bus.mac_acc <= bus.mac_acc + 32'(bus.mac_a) * 32'(bus.mac_b);
      pair_log.push_back({bus.mac_b, bus.mac_a});
    end
  end

  always @(negedge clk_i) begin
    if (bus.mac_clear) clear_cnt++;
    if (bus.obi_req) req_seen++;
  end

  task automatic clear_cfg();
    for (int i = 0; i < 64; i++) begin gnt_stall[i] = 0; rv_lat[i] = 0; rdy_stall[i] = 0; end
    err_at = -1;
  endtask

  // Reference: pair i reads word (base & ~3) + 4i; costs REQ(1+gnt stall), WAIT(1+latency),
  // ISSUE(1+ready stall); an error response ends the job straight after WAIT.
  task automatic model_job(input logic [31:0] base, input int len,
                           output int exp_cyc, output logic [31:0] exp_res, output bit exp_err);
    logic [31:0] a, w;
    exp_addr.delete(); exp_pair.delete();
    exp_res = '0; exp_err = 1'b0; exp_cyc = 1;
    if (len == 0) begin exp_cyc = 2; return; end
    for (int i = 0; i < len; i++) begin
      a = (base & ~32'h3) + 32'(4 * i);
      exp_addr.push_back(a);
      exp_cyc += 2 + gnt_stall[i] + rv_lat[i];
      if (i == err_at) begin exp_err = 1'b1; exp_cyc += 1; return; end
      w = rom_word(a);
      exp_pair.push_back(w);
      exp_res += 32'(w[15:0]) * 32'(w[31:16]);
      exp_cyc += 1 + rdy_stall[i];
    end
    exp_cyc += 2;
  endtask

  // Runs one job; returns in the first IDLE cycle after DONE (done_cyc = -1 on timeout).
  task automatic run_job(input logic [31:0] base, input int len,
                         input bit poke_issue, input bit poke_done, output int done_cyc);
    int c;
    bit poked;
    addr_log.delete(); pair_log.delete();
    req_n = 0; iss_n = 0; clear_cnt = 0; req_seen = 0; stable_err = 0;
    @(negedge clk_i); start_i = 1'b1; base_addr_i = base; len_i = 10'(len);
    @(negedge clk_i); start_i = 1'b0; base_addr_i = $urandom; len_i = 10'($urandom);
    c = 1; done_cyc = -1; poked = 1'b0;
    while (c < 3000) begin
      if (done_o) begin
        done_cyc = c;
        if (poke_done) start_i = 1'b1;
        break;
      end
      if (poke_issue && !poked && bus.mac_valid) begin start_i = 1'b1; poked = 1'b1; end
      else start_i = 1'b0;
      @(negedge clk_i); c++;
    end
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    tests_run++; if ({busy_o, done_o, err_o, result_o} !== '0) begin tests_failed++; $display("FAIL reset_status: got %h expected 0", {busy_o, done_o, err_o, result_o}); end
    tests_run++; if ({bus.obi_req, bus.obi_addr, bus.mac_clear, bus.mac_valid, bus.mac_a, bus.mac_b} !== '0) begin tests_failed++; $display("FAIL reset_bus: got %h expected 0", {bus.obi_req, bus.obi_addr, bus.mac_clear, bus.mac_valid, bus.mac_a, bus.mac_b}); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_basic(input string tag);
    int done_cyc, d;
    clear_cfg();
    exp_addr = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008};
    exp_pair = '{32'h0003_0002, 32'h0005_0004, 32'h0007_0006};
    run_job(32'h2000_0000, 3, 1'b0, 1'b0, done_cyc);
    tests_run++; if (done_cyc !== 12) begin tests_failed++; $display("FAIL %s_done_cycle: got %0d expected 12", tag, done_cyc); end
    d = q_diff(addr_log, exp_addr);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL %s_addrs: got %0d addrs expected 3, first diff at %0d", tag, addr_log.size(), d); end
    d = q_diff(pair_log, exp_pair);
    tests_run++; if (d != -1) begin tests_failed++; $display("FAIL %s_pairs: got %0d pairs expected 3, first diff at %0d", tag, pair_log.size(), d); end
    tests_run++; if (result_o !== 32'd68) begin tests_failed++; $display("FAIL %s_result: got %0d expected 68", tag, result_o); end
    tests_run++; if ({err_o, busy_o, done_o} !== 3'b000) begin tests_failed++; $display("FAIL %s_flags_after: got err/busy/done %b expected 000", tag, {err_o, busy_o, done_o}); end
    tests_run++; if (clear_cnt !== 1) begin tests_failed++; $display("FAIL %s_clear_count: got %0d expected 1", tag, clear_cnt); end
  endtask

  task automatic test_len_zero();
    int done_cyc;
    clear_cfg();
    run_job(32'h2000_0000, 0, 1'b0, 1'b0, done_cyc);
    tests_run++; if (done_cyc !== 2) begin tests_failed++; $display("FAIL len0_done_cycle: got %0d expected 2", done_cyc); end
    tests_run++; if (clear_cnt !== 1) begin tests_failed++; $display("FAIL len0_clear_count: got %0d expected 1", clear_cnt); end
    tests_run++; if (req_seen !== 0) begin tests_failed++; $display("FAIL len0_req_cycles: got %0d expected 0", req_seen); end
    tests_run++; if (result_o !== 32'd0) begin tests_failed++; $display("FAIL len0_result: got %0d expected 0", result_o); end
  endtask

  task automatic test_stalls();
    int done_cyc;
    clear_cfg();
    gnt_stall[0] = 2; rdy_stall[1] = 3;
    run_job(32'h2000_0000, 3, 1'b0, 1'b0, done_cyc);
    tests_run++; if (done_cyc !== 17) begin tests_failed++; $display("FAIL stall_done_cycle: got %0d expected 17", done_cyc); end
    tests_run++; if (result_o !== 32'd68) begin tests_failed++; $display("FAIL stall_result: got %0d expected 68", result_o); end
    tests_run++; if (stable_err !== 0) begin tests_failed++; $display("FAIL stall_hold_stable: got %0d changes expected 0", stable_err); end
    tests_run++; if (addr_log.size() !== 3) begin tests_failed++; $display("FAIL stall_req_count: got %0d expected 3", addr_log.size()); end
  endtask

  task automatic test_error();
    int done_cyc;
    clear_cfg();
    err_at = 1;
    run_job(32'h2000_0000, 3, 1'b0, 1'b0, done_cyc);
    tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL err_flag: got %b expected 1", err_o); end
    tests_run++; if (done_cyc !== 7) begin tests_failed++; $display("FAIL err_done_cycle: got %0d expected 7", done_cyc); end
    tests_run++; if (pair_log.size() !== 1) begin tests_failed++; $display("FAIL err_pairs: got %0d expected 1", pair_log.size()); end
    tests_run++; if (result_o !== 32'd6) begin tests_failed++; $display("FAIL err_result: got %0d expected 6", result_o); end
    repeat (3) @(negedge clk_i);
    tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    test_basic("err_clear");
  endtask

  task automatic test_start_ignored();
    int done_cyc;
    clear_cfg();
    run_job(32'h2000_0000, 3, 1'b1, 1'b1, done_cyc);
    tests_run++; if (done_cyc !== 12) begin tests_failed++; $display("FAIL ignore_done_cycle: got %0d expected 12", done_cyc); end
    tests_run++; if (q_diff(addr_log, '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008}) != -1) begin tests_failed++; $display("FAIL ignore_addrs: got %0d addrs expected 3 from 0x20000000", addr_log.size()); end
    tests_run++; if (result_o !== 32'd68) begin tests_failed++; $display("FAIL ignore_result: got %0d expected 68", result_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL ignore_no_restart: got busy %b expected 0", busy_o); end
  endtask

  task automatic test_reset_mid_job();
    int guard;
    clear_cfg();
    rv_lat[0] = 6;
    addr_log.delete(); req_n = 0; iss_n = 0;
    @(negedge clk_i); start_i = 1'b1; base_addr_i = 32'h2000_0000; len_i = 10'd3;
    @(negedge clk_i); start_i = 1'b0;
    guard = 0;
    while (!(addr_log.size() == 1 && !bus.obi_req) && guard < 50) begin @(negedge clk_i); guard++; end
    tests_run++; if (guard >= 50) begin tests_failed++; $display("FAIL rst_reach_wait: got timeout after %0d cycles expected WAIT", guard); end
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    tests_run++; if ({busy_o, done_o, err_o, result_o, bus.obi_req, bus.obi_addr, bus.mac_clear, bus.mac_valid, bus.mac_a, bus.mac_b} !== '0) begin tests_failed++; $display("FAIL rst_mid_outputs: got busy %b addr %h expected all 0", busy_o, bus.obi_addr); end
    @(negedge clk_i); rst_ni = 1'b1;
    test_basic("after_rst");
  endtask

  task automatic test_wrap();
    int done_cyc, exp_cyc;
    logic [31:0] exp_res;
    bit exp_err;
    clear_cfg();
    model_job(32'hFFFF_FFFC, 2, exp_cyc, exp_res, exp_err);
    run_job(32'hFFFF_FFFC, 2, 1'b0, 1'b0, done_cyc);
    tests_run++; if (addr_log.size() != 2 || addr_log[1] !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_addr: got %0d addrs, second %h expected 00000000", addr_log.size(), (addr_log.size() > 1) ? addr_log[1] : 32'hx); end
    tests_run++; if (result_o !== exp_res) begin tests_failed++; $display("FAIL wrap_result: got %h expected %h", result_o, exp_res); end
    run_job(32'h2000_0003, 1, 1'b0, 1'b0, done_cyc);
    tests_run++; if (addr_log.size() != 1 || addr_log[0] !== 32'h2000_0000) begin tests_failed++; $display("FAIL align_addr: got %0d addrs, first %h expected 20000000", addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hx); end
    tests_run++; if (result_o !== 32'd6) begin tests_failed++; $display("FAIL align_result: got %0d expected 6", result_o); end
  endtask

  task automatic test_random();
    int done_cyc, exp_cyc, len, d;
    logic [31:0] base, exp_res;
    bit exp_err;
    for (int j = 0; j < 10; j++) begin
      clear_cfg();
      base = $urandom;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        gnt_stall[i] = $urandom_range(0, 2); rv_lat[i] = $urandom_range(0, 3); rdy_stall[i] = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 3) == 0) err_at = $urandom_range(0, len - 1);
      model_job(base, len, exp_cyc, exp_res, exp_err);
      run_job(base, len, 1'b0, 1'b0, done_cyc);
      tests_run++; if (done_cyc !== exp_cyc) begin tests_failed++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", j, done_cyc, exp_cyc); end
      d = q_diff(addr_log, exp_addr);
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rnd%0d_addrs: got %0d addrs expected %0d, first diff at %0d", j, addr_log.size(), exp_addr.size(), d); end
      d = q_diff(pair_log, exp_pair);
      tests_run++; if (d != -1) begin tests_failed++; $display("FAIL rnd%0d_pairs: got %0d pairs expected %0d, first diff at %0d", j, pair_log.size(), exp_pair.size(), d); end
      tests_run++; if (result_o !== exp_res) begin tests_failed++; $display("FAIL rnd%0d_result: got %h expected %h", j, result_o, exp_res); end
      tests_run++; if (err_o !== exp_err) begin tests_failed++; $display("FAIL rnd%0d_err: got %b expected %b", j, err_o, exp_err); end
      tests_run++; if (stable_err !== 0) begin tests_failed++; $display("FAIL rnd%0d_hold_stable: got %0d changes expected 0", j, stable_err); end
    end
  endtask

  initial begin
    rom[32'h2000_0000] = 32'h0003_0002;
    rom[32'h2000_0004] = 32'h0005_0004;
    rom[32'h2000_0008] = 32'h0007_0006;
    clear_cfg();
    test_reset();
    test_basic("basic");
    test_len_zero();
    test_stalls();
    test_error();
    test_start_ignored();
    test_reset_mid_job();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
